product_display: RTL and testbench

Downstream display stage of the multiplier top level. It consumes the 16-bit signed product when the multiplier signals completion and converts the magnitude to five BCD digits with a sequential double-dabble. It drives a time-multiplexed 4-digit active-low seven-segment display. Debounced single-cycle shift-left/shift-right pulses scroll a 4-character window over the 6-character result (sign plus 5 digits).

---
 rtl/display_pkg.sv | 42 ++++
 rtl/bin2bcd_seq.sv | 63 ++++++
 rtl/product_display.sv | 138 +++++++++++++
 tb/tb_product_display.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared encodings for the product display path: character codes, segment patterns, FSM states.
package display_pkg;

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CHAR_W = 4;

    localparam logic [CHAR_W-1:0] CH_BLANK = 4'd10;
    localparam logic [CHAR_W-1:0] CH_MINUS = 4'd11;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    // Active-low {g,f,e,d,c,b,a} pattern for a character code.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [CHAR_W-1:0] ch);
        logic [SEG_W-1:0] seg;
        case (ch)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            CH_MINUS: seg = SEG_MINUS;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit unsigned to 5 BCD digits, one shift per cycle.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [3:0] ITER_LAST = 4'(BIN_W - 1);

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [BCD_W-1:0] w_adj;

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bin  <= i_bin;
                r_bcd  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
                r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == ITER_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_bcd  = r_bcd;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/product_display.sv
// Signed product to scrolling, time-multiplexed 4-digit seven-segment display.
module product_display
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] product,
    input  logic             product_valid,
    input  logic             shift_left,
    input  logic             shift_right,
    output logic [SEG_W-1:0] segments,
    output logic [3:0]       anodes,
    output logic             busy,
    output logic [1:0]       offset
);

    localparam int unsigned REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

    state_t           r_state;
    logic             r_sign;
    logic             r_neg;
    logic             r_busy;
    logic [BCD_W-1:0] r_digits;
    logic [1:0]       r_offset;
    logic [REF_W-1:0] r_ref;
    logic [1:0]       r_dsel;
    logic [SEG_W-1:0] r_segments;
    logic [3:0]       r_anodes;

    logic [BIN_W-1:0]  w_mag;
    logic              w_start;
    logic [BCD_W-1:0]  w_bcd;
    logic              w_cvt_busy;
    logic              w_cvt_done;
    logic [2:0]        w_pos;
    logic [BCD_W-1:0]  w_upper;
    logic [CHAR_W-1:0] w_char;

    assign w_mag   = product[BIN_W-1] ? BIN_W'(~product + 16'd1) : product;
    assign w_start = (r_state == IDLE) && product_valid && !w_cvt_busy;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_bin   (w_mag),
        .o_bcd   (w_bcd),
        .o_busy  (w_cvt_busy),
        .o_done  (w_cvt_done)
    );

    // Conversion sequencing; pulses arriving outside IDLE are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_digits <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_sign  <= product[BIN_W-1];
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_busy <= 1'b1;
                    if (w_cvt_done) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_digits <= w_bcd;
                    r_neg    <= r_sign;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset <= '0;
        end else if (shift_left && !shift_right && r_offset != 2'd2) begin
            r_offset <= r_offset + 2'd1;
        end else if (shift_right && !shift_left && r_offset != 2'd0) begin
            r_offset <= r_offset - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref  <= '0;
            r_dsel <= '0;
        end else if (r_ref == REF_LAST) begin
            r_ref  <= '0;
            r_dsel <= r_dsel + 2'd1;
        end else begin
            r_ref <= r_ref + REF_W'(1);
        end
    end

    // A digit is blanked when it and every more-significant digit are zero, except the ones digit.
    assign w_pos   = 3'(r_offset) + 3'(r_dsel);
    assign w_upper = r_digits >> {w_pos, 2'b00};

    always_comb begin
        w_char = CH_BLANK;
        if (w_pos == 3'd5) begin
            w_char = r_neg ? CH_MINUS : CH_BLANK;
        end else if (w_pos == 3'd0 || w_upper != '0) begin
            w_char = w_upper[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segments <= SEG_BLANK;
            r_anodes   <= 4'hF;
        end else begin
            r_segments <= seg_encode(w_char);
            r_anodes   <= ~(4'b0001 << r_dsel);
        end
    end

    assign segments = r_segments;
    assign anodes   = r_anodes;
    assign busy     = r_busy;
    assign offset   = r_offset;

endmodule

// File: tb/tb_product_display.sv
// Directed bench for product_display with a value-level reference model checked every cycle.
module tb_product_display;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] product = '0;
    logic        product_valid = 1'b0;
    logic        shift_left = 1'b0;
    logic        shift_right = 1'b0;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic        busy;
    logic [1:0]  offset;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_seg = 7'h7F;
    logic [3:0] exp_an = 4'hF;
    logic       exp_busy = 1'b0;
    logic [1:0] exp_off = 2'd0;

    int m_val = 0;
    int m_pend = 0;
    int m_off = 0;
    int m_k = 0;
    int m_phase = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    product_display #(.REFRESH_CYCLES(R)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .product       (product),
        .product_valid (product_valid),
        .shift_left    (shift_left),
        .shift_right   (shift_right),
        .segments      (segments),
        .anodes        (anodes),
        .busy          (busy),
        .offset        (offset)
    );

    always #5 clk = ~clk;

    // Character at position p of a signed value, in decimal terms.
    function automatic logic [6:0] char_seg(input int v, input int p);
        int mag;
        int pw;
        mag = (v < 0) ? -v : v;
        pw = 1;
        for (int i = 0; i < p; i++) pw = pw * 10;
        if (p == 5) return (v < 0) ? 7'b0111111 : 7'b1111111;
        if (p > 0 && mag < pw) return 7'b1111111;
        return seg_tab[(mag / pw) % 10];
    endfunction

    // Reference model: what each edge must produce from the state before that edge.
    initial begin
        int d;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_val = 0; m_off = 0; m_k = 0; m_phase = 0;
                exp_an = 4'hF; exp_seg = 7'h7F; exp_busy = 1'b0; exp_off = 2'd0;
            end else begin
                d = (m_k / R) % 4;
                exp_an = 4'(~(4'b0001 << d));
                exp_seg = char_seg(m_val, m_off + d);
                m_k++;
                if (shift_left && !shift_right && m_off < 2) m_off++;
                else if (shift_right && !shift_left && m_off > 0) m_off--;
                if (m_phase == 0) begin
                    if (product_valid) begin
                        m_phase = 1;
                        m_pend = int'($signed(product));
                    end
                end else begin
                    m_phase++;
                    if (m_phase == 19) begin
                        m_val = m_pend;
                        m_phase = 0;
                    end
                end
                exp_busy = (m_phase >= 2 && m_phase <= 18);
                exp_off = 2'(m_off);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model_anodes", 32'(anodes), 32'(exp_an));
        chk("model_segments", 32'(segments), 32'(exp_seg));
        chk("model_busy", 32'(busy), 32'(exp_busy));
        chk("model_offset", 32'(offset), 32'(exp_off));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_valid(input logic [15:0] v);
        product = v;
        product_valid = 1'b1;
        tick();
        product_valid = 1'b0;
    endtask

    task automatic pulse_shift(input logic l, input logic r);
        shift_left = l;
        shift_right = r;
        tick();
        shift_left = 1'b0;
        shift_right = 1'b0;
        tick();
    endtask

    task automatic find_an(input logic [3:0] an, input logic [6:0] seg, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            tick();
            if (anodes == an) begin
                chk(name, 32'(segments), 32'(seg));
                found = 1'b1;
            end
        end
        if (!found) chk({name, "_scan_timeout"}, 32'(anodes), 32'(an));
    endtask

    initial begin
        int busy_cnt;

        ticks(3);
        chk("reset_anodes", 32'(anodes), 32'h0000000F);
        chk("reset_segments", 32'(segments), 32'h0000007F);
        rst_n = 1'b1;
        tick();
        chk("first_anodes", 32'(anodes), 32'b1110);
        chk("first_segments", 32'(segments), 32'b1000000);
        chk("first_offset", 32'(offset), 32'd0);
        chk("first_busy", 32'(busy), 32'd0);

        pulse_valid(16'd50);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("busy_len_50", 32'(busy_cnt), 32'd17);
        find_an(4'b0111, 7'b1111111, "p50_d3");
        find_an(4'b1011, 7'b1111111, "p50_d2");
        find_an(4'b1101, 7'b0010010, "p50_d1");
        find_an(4'b1110, 7'b1000000, "p50_d0");

        pulse_valid(16'hC000);
        ticks(25);
        find_an(4'b0111, 7'b0000010, "neg_d3");
        find_an(4'b1011, 7'b0110000, "neg_d2");
        find_an(4'b1101, 7'b0000000, "neg_d1");
        find_an(4'b1110, 7'b0011001, "neg_d0");
        pulse_shift(1'b1, 1'b0);
        pulse_shift(1'b1, 1'b0);
        chk("offset_after_two_left", 32'(offset), 32'd2);
        find_an(4'b0111, 7'b0111111, "neg_off2_d3");
        find_an(4'b1011, 7'b1111001, "neg_off2_d2");
        find_an(4'b1101, 7'b0000010, "neg_off2_d1");
        find_an(4'b1110, 7'b0110000, "neg_off2_d0");
        pulse_shift(1'b1, 1'b0);
        chk("offset_sat_high", 32'(offset), 32'd2);

        pulse_shift(1'b0, 1'b1);
        pulse_shift(1'b0, 1'b1);
        pulse_shift(1'b0, 1'b1);
        chk("offset_sat_low", 32'(offset), 32'd0);
        pulse_shift(1'b1, 1'b0);
        pulse_shift(1'b1, 1'b1);
        chk("offset_both", 32'(offset), 32'd1);
        pulse_shift(1'b0, 1'b1);

        pulse_valid(16'h8000);
        ticks(4);
        pulse_valid(16'd7);
        ticks(25);
        find_an(4'b0111, 7'b0100100, "min_d3");
        find_an(4'b1011, 7'b1111000, "min_d2");
        find_an(4'b1101, 7'b0000010, "min_d1");
        find_an(4'b1110, 7'b0000000, "min_d0");
        pulse_shift(1'b1, 1'b0);
        pulse_shift(1'b1, 1'b0);
        find_an(4'b0111, 7'b0111111, "min_sign");
        find_an(4'b1011, 7'b0110000, "min_d4");
        pulse_shift(1'b0, 1'b1);
        pulse_shift(1'b0, 1'b1);

        pulse_valid(16'd0);
        ticks(25);
        find_an(4'b1110, 7'b1000000, "zero_d0");
        find_an(4'b1101, 7'b1111111, "zero_d1");
        find_an(4'b1011, 7'b1111111, "zero_d2");
        find_an(4'b0111, 7'b1111111, "zero_d3");

        pulse_valid(16'd1234);
        ticks(8);
        rst_n = 1'b0;
        tick();
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_anodes", 32'(anodes), 32'h0000000F);
        tick();
        rst_n = 1'b1;
        ticks(30);
        find_an(4'b1110, 7'b1000000, "after_rst_d0");
        find_an(4'b1101, 7'b1111111, "after_rst_d1");
        pulse_shift(1'b1, 1'b0);
        pulse_shift(1'b1, 1'b0);
        find_an(4'b0111, 7'b1111111, "after_rst_sign");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
